// File: rtl/uart_pkg.sv
// Shared encodings and constants for the configurable UART transmitter.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 8;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'b00,
        PARITY_EVEN = 2'b01,
        PARITY_ODD  = 2'b10
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; tick marks the last cycle of each loaded period.
module uart_bit_timer #(
    parameter int unsigned WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] period,
    output logic             tick
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= period - WIDTH'(1);
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// AXI4-Stream UART transmitter with selectable parity, 1/2 stop bits and break.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic                      txd,
    output logic                      busy,
    output logic                      tx_done,
    input  logic [1:0]                parity_mode,
    input  logic                      stop2,
    input  logic                      tx_break,
    input  logic [PRESCALE_WIDTH-1:0] prescale
);

    localparam int unsigned TW = PRESCALE_WIDTH + 3;

    tx_state_e               state;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [3:0]              bit_cnt;
    logic                    par_en_q;
    logic                    par_bit_q;
    logic                    stop2_q;
    logic                    stop_second;
    logic                    brk_mark;
    logic [TW-1:0]           p_q;
    logic                    ready_q;

    logic [PRESCALE_WIDTH-1:0] ps_nz;
    logic [TW-1:0]             p_now;
    logic [TW-1:0]             tmr_period;
    logic                      tmr_load;
    logic                      tick;
    logic                      xfer;

    // A break request masks the registered ready so a word offered in the
    // same cycle is never handshaken.
    assign s_axis_tready = ready_q & ~tx_break;
    assign xfer          = s_axis_tvalid & s_axis_tready;

    always_comb begin
        ps_nz = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
        p_now = TW'(ps_nz) * TW'(OVERSAMPLE);
    end

    always_comb begin
        tmr_load   = 1'b0;
        tmr_period = p_q;
        case (state)
            IDLE: begin
                tmr_period = p_now;
                tmr_load   = xfer | tx_break;
            end
            BREAK:   tmr_load = ~tx_break & ~brk_mark;
            default: tmr_load = tick;
        endcase
    end

    uart_bit_timer #(.WIDTH(TW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .period (tmr_period),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            txd         <= 1'b1;
            ready_q     <= 1'b0;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            stop2_q     <= 1'b0;
            stop_second <= 1'b0;
            brk_mark    <= 1'b0;
            p_q         <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    txd     <= 1'b1;
                    busy    <= 1'b0;
                    ready_q <= ~tx_break;
                    if (tx_break) begin
                        state    <= BREAK;
                        txd      <= 1'b0;
                        busy     <= 1'b1;
                        ready_q  <= 1'b0;
                        brk_mark <= 1'b0;
                        p_q      <= p_now;
                    end else if (xfer) begin
                        state       <= START;
                        txd         <= 1'b0;
                        busy        <= 1'b1;
                        ready_q     <= 1'b0;
                        shreg       <= s_axis_tdata;
                        bit_cnt     <= '0;
                        par_en_q    <= (parity_mode == PARITY_EVEN) || (parity_mode == PARITY_ODD);
                        par_bit_q   <= (^s_axis_tdata) ^ (parity_mode == PARITY_ODD);
                        stop2_q     <= stop2;
                        stop_second <= 1'b0;
                        p_q         <= p_now;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        txd     <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= 4'd1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == 4'(DATA_WIDTH)) begin
                            state <= par_en_q ? PARITY : STOP;
                            txd   <= par_en_q ? par_bit_q : 1'b1;
                        end else begin
                            txd     <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state <= STOP;
                        txd   <= 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (stop2_q && !stop_second) begin
                            stop_second <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            tx_done <= 1'b1;
                            ready_q <= ~tx_break;
                        end
                    end
                end
                BREAK: begin
                    if (!brk_mark) begin
                        if (!tx_break) begin
                            brk_mark <= 1'b1;
                            txd      <= 1'b1;
                        end
                    end else if (tick) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        ready_q <= ~tx_break;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg against a slot-level serial frame model.
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic        txd;
    logic        busy;
    logic        tx_done;
    logic [1:0]  parity_mode;
    logic        stop2;
    logic        tx_break;
    logic [15:0] prescale;

    logic [6:0]  d7_tdata;
    logic        d7_tvalid;
    logic        d7_tready;
    logic        d7_txd;
    logic        d7_busy;
    logic        d7_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_WIDTH(8), .PRESCALE_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tready(tready), .txd(txd), .busy(busy), .tx_done(tx_done),
        .parity_mode(parity_mode), .stop2(stop2), .tx_break(tx_break), .prescale(prescale)
    );

    uart_tx_cfg #(.DATA_WIDTH(7), .PRESCALE_WIDTH(16)) dut7 (
        .clk(clk), .rst(rst), .s_axis_tdata(d7_tdata), .s_axis_tvalid(d7_tvalid),
        .s_axis_tready(d7_tready), .txd(d7_txd), .busy(d7_busy), .tx_done(d7_done),
        .parity_mode(parity_mode), .stop2(stop2), .tx_break(tx_break), .prescale(prescale)
    );

    // Line level expected in a given bit slot of a frame.
    function automatic logic exp_level(input logic [8:0] data, input int w,
                                       input logic [1:0] mode, input int slot);
        int par;
        int ones;
        logic [8:0] mask;
        par  = (mode == 2'd1 || mode == 2'd2) ? 1 : 0;
        mask = (9'd1 << w) - 9'd1;
        ones = $countones(data & mask);
        if (slot == 0) return 1'b0;
        if (slot <= w) return data[slot-1];
        if (par == 1 && slot == w + 1) return ((ones % 2) == 1) ^ (mode == 2'd2);
        return 1'b1;
    endfunction

    function automatic int n_slots(input int w, input logic [1:0] mode, input bit s2);
        return 2 + w + ((mode == 2'd1 || mode == 2'd2) ? 1 : 0) + (s2 ? 1 : 0);
    endfunction

    // disturb: 0 none, 1 change config mid-frame, 2 pulse tx_break mid-frame
    task automatic send8(input logic [7:0] d, input logic [1:0] m, input bit s2,
                         input int ps, input int disturb, input string name,
                         output int waited);
        int p;
        int total;
        int bad;
        p      = ((ps == 0) ? 1 : ps) * 8;
        total  = n_slots(8, m, s2) * p;
        waited = 0;
        bad    = 0;
        @(negedge clk);
        tdata = d; tvalid = 1'b1; parity_mode = m; stop2 = s2; prescale = ps[15:0];
        while (!tready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (tready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: tready=%b required 1", name, tready);
            tvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        tvalid = 1'b0;
        for (int k = 0; k < total; k++) begin
            checks++;
            if (txd !== exp_level({1'b0, d}, 8, m, k / p) || busy !== 1'b1 || tx_done !== 1'b0) begin
                errors++;
                if (bad < 4)
                    $display("FAIL %s cycle %0d: txd=%b busy=%b done=%b required txd=%b busy=1 done=0",
                             name, k, txd, busy, tx_done, exp_level({1'b0, d}, 8, m, k / p));
                bad++;
            end
            if (disturb == 1 && k == 5) begin
                parity_mode = 2'($urandom);
                stop2       = ~s2;
                prescale    = 16'($urandom_range(0, 5));
            end
            if (disturb == 2 && k == 20) tx_break = 1'b1;
            if (disturb == 2 && k == 40) tx_break = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (tx_done !== 1'b1 || busy !== 1'b0 || txd !== 1'b1) begin
            errors++;
            $display("FAIL %s end: done=%b busy=%b txd=%b required done=1 busy=0 txd=1",
                     name, tx_done, busy, txd);
        end
        @(posedge clk); #1;
        checks++;
        if (tx_done !== 1'b0 || tready !== 1'b1) begin
            errors++;
            $display("FAIL %s after: done=%b tready=%b required done=0 tready=1", name, tx_done, tready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tvalid = 1'b0; tdata = '0; parity_mode = 2'd0; stop2 = 1'b0;
        tx_break = 1'b0; prescale = 16'd1; d7_tvalid = 1'b0; d7_tdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (txd !== 1'b1 || tready !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: txd=%b tready=%b busy=%b done=%b required 1 0 0 0",
                     txd, tready, busy, tx_done);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (tready !== 1'b1 || d7_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: tready=%b d7_tready=%b required 1 1", tready, d7_tready);
        end
    endtask

    task automatic test_8n1();
        int w;
        send8(8'hA5, 2'd0, 1'b0, 1, 0, "8n1_a5", w);
    endtask

    task automatic test_parity();
        int w;
        send8(8'hA5, 2'd1, 1'b0, 1, 0, "even_a5", w);
        send8(8'hA5, 2'd2, 1'b0, 1, 0, "odd_a5", w);
        send8(8'h01, 2'd3, 1'b1, 0, 0, "mode3_none", w);
    endtask

    task automatic test_random();
        int w;
        for (int i = 0; i < 8; i++)
            send8(8'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, 3),
                  (i % 2 == 1) ? 1 : 0, "random", w);
    endtask

    task automatic test_dw7();
        int n;
        int bad;
        n = 0; bad = 0;
        @(negedge clk);
        parity_mode = 2'd0; stop2 = 1'b1; prescale = 16'd2; d7_tdata = 7'h7F; d7_tvalid = 1'b1;
        while (!d7_tready && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (d7_tready !== 1'b1) begin
            errors++;
            $display("FAIL dw7 accept: tready=%b required 1", d7_tready);
            d7_tvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        d7_tvalid = 1'b0;
        for (int k = 0; k < 160; k++) begin
            checks++;
            if (d7_txd !== exp_level({2'b0, 7'h7F}, 7, 2'd0, k / 16) || d7_busy !== 1'b1 || d7_done !== 1'b0) begin
                errors++;
                if (bad < 4)
                    $display("FAIL dw7 cycle %0d: txd=%b busy=%b done=%b", k, d7_txd, d7_busy, d7_done);
                bad++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (d7_done !== 1'b1 || d7_busy !== 1'b0) begin
            errors++;
            $display("FAIL dw7 done: done=%b busy=%b required 1 0", d7_done, d7_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        int xcyc [3];
        int idx;
        int ready_busy;
        bit hs;
        idx = 0; ready_busy = 0;
        for (int i = 0; i < 3; i++) words[i] = 8'($urandom);
        @(negedge clk);
        parity_mode = 2'd0; stop2 = 1'b0; prescale = 16'd1;
        tdata = words[0]; tvalid = 1'b1;
        for (int cyc = 0; cyc < 400 && idx < 3; cyc++) begin
            if (cyc != 0) @(negedge clk);
            hs = tvalid && tready;
            if (hs) xcyc[idx] = cyc;
            @(posedge clk); #1;
            if (tready && busy) ready_busy++;
            if (hs) begin
                idx++;
                if (idx < 3) tdata = words[idx];
                else tvalid = 1'b0;
            end
        end
        tvalid = 1'b0;
        checks++;
        if (idx !== 3) begin
            errors++;
            $display("FAIL b2b count: transfers=%0d required 3", idx);
        end else begin
            checks++;
            if (xcyc[1] - xcyc[0] !== 81 || xcyc[2] - xcyc[1] !== 81) begin
                errors++;
                $display("FAIL b2b spacing: %0d %0d required 81 81", xcyc[1] - xcyc[0], xcyc[2] - xcyc[1]);
            end
        end
        checks++;
        if (ready_busy !== 0) begin
            errors++;
            $display("FAIL b2b tready_in_frame: cycles=%0d required 0", ready_busy);
        end
        repeat (90) @(posedge clk);
        #1;
    endtask

    task automatic test_break();
        int w;
        int bad;
        bad = 0;
        @(negedge clk);
        parity_mode = 2'd0; stop2 = 1'b0; prescale = 16'd1;
        tdata = 8'h3C; tvalid = 1'b1; tx_break = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            checks++;
            if (txd !== 1'b0 || busy !== 1'b1 || tready !== 1'b0) begin
                errors++;
                if (bad < 4)
                    $display("FAIL break hold %0d: txd=%b busy=%b tready=%b required 0 1 0", i, txd, busy, tready);
                bad++;
            end
        end
        @(negedge clk); tx_break = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if (txd !== 1'b1 || busy !== 1'b1 || tready !== 1'b0 || tx_done !== 1'b0) begin
                errors++;
                $display("FAIL break mark %0d: txd=%b busy=%b tready=%b done=%b required 1 1 0 0",
                         i, txd, busy, tready, tx_done);
            end
        end
        send8(8'h3C, 2'd0, 1'b0, 1, 0, "after_break", w);
        checks++;
        if (w !== 1) begin
            errors++;
            $display("FAIL break accept_delay: waited=%0d required 1", w);
        end
        send8(8'($urandom), 2'd1, 1'b1, 1, 2, "break_midframe", w);
    endtask

    task automatic test_reset_mid();
        int w;
        @(negedge clk);
        parity_mode = 2'd0; stop2 = 1'b0; prescale = 16'd1;
        tdata = 8'h5A; tvalid = 1'b1;
        @(posedge clk); #1;
        tvalid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (txd !== 1'b1 || tready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid async: txd=%b tready=%b busy=%b required 1 0 0", txd, tready, busy);
        end
        @(negedge clk); rst = 1'b0;
        #1;
        checks++;
        if (tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid pre_edge: tready=%b required 0", tready);
        end
        @(posedge clk); #1;
        checks++;
        if (tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid release: tready=%b required 1", tready);
        end
        send8(8'($urandom), 2'd2, 1'b0, 2, 0, "after_reset", w);
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_random();
        test_dw7();
        test_back_to_back();
        test_break();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised AXI4-Stream UART transmitter, the successor to the fixed 8N1 transmitter. It adds run-time selectable parity (none/even/odd), 1 or 2 stop bits, break generation and a frame-done pulse. The data width and prescaler width are compile-time parameters. It sits between a byte/word stream source (FIFO, register block) and the txd pin, alongside the existing receiver.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal 5..9.
PRESCALE_WIDTH, 16, width of the prescale input.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
s_axis_tdata  in  DATA_WIDTH  word to send, LSB transmitted first
s_axis_tvalid  in  1  source has a word
s_axis_tready  out  1  block accepts a word this cycle
txd  out  1  serial output, idle high
busy  out  1  frame or break in progress
tx_done  out  1  one-cycle pulse when the last stop bit completes
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
stop2  in  1  0 = one stop bit, 1 = two stop bits
tx_break  in  1  hold txd low while asserted (from idle)
prescale  in  PRESCALE_WIDTH  bit period = prescale*8 clk cycles

Behaviour:
- Reset (async assert, sync release): txd=1, s_axis_tready=0, busy=0, tx_done=0, state IDLE, all counters 0.
- Bit period P = max(prescale,1)*8 cycles. The counter is PRESCALE_WIDTH+3 bits, so it cannot overflow.
- Handshake: transfer occurs on a cycle where s_axis_tvalid && s_axis_tready.
  - s_axis_tready is registered and is 1 only in IDLE with tx_break=0.
  - It rises on the first clk after reset release.
  - It drops the cycle after a transfer.
- At transfer, the block latches tdata, parity_mode, stop2 and P. Config changes mid-frame have no effect on the current frame.
- States:
  - IDLE: txd=1, busy=0. On transfer -> START. If tx_break=1 -> BREAK; break has priority over a simultaneous tvalid, which is not accepted.
  - START: txd=0 for P cycles -> DATA.
  - DATA: DATA_WIDTH bits LSB first, P cycles each. Then -> PARITY if the latched mode is even/odd, else -> STOP.
  - PARITY: txd = XOR of the data bits (even), or its inverse (odd), for P cycles -> STOP.
  - STOP: txd=1 for P cycles (2P if stop2) -> IDLE. tx_done pulses on the cycle the state returns to IDLE.
  - BREAK: txd=0, busy=1, tready=0 while tx_break=1. On deassert: txd=1 for P cycles (mark-after-break) -> IDLE. tx_done is not pulsed.
- busy=1 from the cycle after transfer (or break entry) until the return to IDLE.
- tx_break asserted mid-frame is ignored until IDLE. The frame is never truncated.
- Latency: txd falls on the clk after the transfer cycle.
- Back-to-back: minimum frame-to-frame spacing is (1+DATA_WIDTH+parity+stops)*P + 1 cycles, because IDLE lasts at least one cycle.
- Reset asserted mid-frame: txd returns high immediately (async) and the word is lost.

Decomposition:
- Package uart_pkg:
  - parity encodings PARITY_NONE/EVEN/ODD;
  - tx state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - oversample constant OVERSAMPLE=8.
- Sub-module uart_bit_timer:
  - loadable down-counter of width PRESCALE_WIDTH+3;
  - inputs: load, period;
  - output: tick on the last cycle of the period.
- The shift register, bit counter and FSM stay in uart_tx_cfg.

Test Plan:
1. prescale=1, 8N1, send 0xA5 -> txd per 8-cycle slot: 0,1,0,1,0,0,1,0,1,1; tx_done pulses at cycle 81 after transfer; busy high 80 cycles.
2. Even parity, send 0xA5 -> parity slot 0. Odd parity -> parity slot 1. Frame is 11 slots.
3. stop2=1, DATA_WIDTH=7 build, prescale=2, send 0x7F -> start + seven 1s + stop high for 32 cycles; total 9*16+16 = 160 cycles to tx_done.
4. tvalid held high, 3 words queued -> exactly 3 transfers; tready low throughout each frame; adjacent start-bit falling edges 80*1+1 = 81 cycles apart (prescale=1, 8N1).
5. tx_break and tvalid rise together in IDLE -> no transfer, txd low while break held 50 cycles, then high 8 cycles, then the word is accepted. tx_break raised mid-frame -> frame completes unchanged.
6. rst pulsed during DATA -> txd=1, tready=0, busy=0 immediately; tready=1 one clk after release; next frame is correct.
